data_mem_ctrl: RTL and testbench

//  Handshaked, parametrised RV32 data memory that replaces the single-cycle data register.

---
 rtl/data_mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Handshaked RV32 data memory: byte/half/word loads and stores with optional wait states.
// Optional feature: define DMEM_MISALIGN_CHK_EN to fault misaligned half/word accesses.
module data_mem_ctrl #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_word;
    logic                  w_range_err;
    logic                  w_type_err;
    logic                  w_align_err;
    logic                  w_err;
    logic [3:0]            w_be;
    logic [31:0]           w_wrep;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ld;
    logic                  w_mem_we;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_done      = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_idx       = r_addr[ADDR_WIDTH+1:2];
    assign w_word      = r_mem[w_idx];
    assign w_range_err = (r_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_type_err  = (r_type[1:0] == 2'b11);

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_align_err = ((r_type[1:0] == 2'b01) && r_addr[0]) ||
                         ((r_type[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    // Misaligned halves/words are force-aligned by the lane selection below.
    assign w_align_err = 1'b0;
`endif

    assign w_err = w_range_err || w_type_err || w_align_err;

    // Gating with rst drops a store caught in ACCESS when reset hits.
    assign w_mem_we = w_done && r_we && !w_err && !rst;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid)  w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE:   req_ready  = 1'b1;
            S_RESP:   resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Request latch: pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_type  <= req_type;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= 4'(WAIT_CYCLES);
            end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) begin
                r_rdata <= (w_err || r_we) ? 32'd0 : w_ld;
                r_err   <= w_err;
            end
        end
    end

    // Load lane selection and extension.
    always_comb begin
        w_byte = 8'd0;
        case (r_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = 8'd0;
        endcase
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        w_ld   = 32'd0;
        case (r_type[1:0])
            2'b00:   w_ld = r_type[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ld = r_type[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_ld = w_word;
            default: w_ld = 32'd0;
        endcase
    end

    // Store byte enables and lane replication.
    always_comb begin
        w_be   = 4'b0000;
        w_wrep = r_wdata;
        case (r_type[1:0])
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_wrep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_wrep = r_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wrep = r_wdata;
            end
        endcase
    end

    // Storage: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (ADDR_WIDTH=8, BASE 0, WAIT_CYCLES=3).
module tb_data_mem_ctrl;

    localparam int WAIT = 3;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_ctrl #(
        .ADDR_WIDTH  (8),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One full request/response; lat counts edges from accept to resp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_type   = typ;
        req_wdata  = wd;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold_rd;
    logic        hold_er;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_type   = 3'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata",      resp_rdata,          32'd0);
        chk("rst_err",        {31'd0, resp_err},   32'd0);

        // 1: word store/load and latency
        xact(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_latency", lat, 1 + WAIT);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_latency", lat, 1 + WAIT);

        // 2: byte store into a word, signed/unsigned byte loads
        xact(1'b1, 32'h10, 3'b010, 32'h11223344, rd, er, lat);
        xact(1'b1, 32'h13, 3'b000, 32'h00000080, rd, er, lat);
        xact(1'b0, 32'h13, 3'b000, 32'd0, rd, er, lat);
        chk("lb", rd, 32'hFFFFFF80);
        xact(1'b0, 32'h13, 3'b100, 32'd0, rd, er, lat);
        chk("lbu", rd, 32'h00000080);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("lw_after_sb", rd, 32'h80223344);

        // 3: half store at upper lane
        xact(1'b1, 32'h20, 3'b010, 32'h00000000, rd, er, lat);
        xact(1'b1, 32'h22, 3'b001, 32'h0000A5A5, rd, er, lat);
        xact(1'b0, 32'h22, 3'b001, 32'd0, rd, er, lat);
        chk("lh", rd, 32'hFFFFA5A5);
        xact(1'b0, 32'h22, 3'b101, 32'd0, rd, er, lat);
        chk("lhu", rd, 32'h0000A5A5);
        xact(1'b0, 32'h20, 3'b010, 32'd0, rd, er, lat);
        chk("lw_after_sh", rd, 32'hA5A50000);

        // 4: errors; 0x410 would alias word 0x10 if the range check failed
        xact(1'b0, 32'h400, 3'b010, 32'd0, rd, er, lat);
        chk("oor_err", {31'd0, er}, 32'd1);
        chk("oor_rdata", rd, 32'd0);
        xact(1'b0, 32'h10, 3'b011, 32'd0, rd, er, lat);
        chk("illegal_err", {31'd0, er}, 32'd1);
        chk("illegal_rdata", rd, 32'd0);
        xact(1'b1, 32'h410, 3'b010, 32'h12345678, rd, er, lat);
        chk("oor_st_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("oor_st_nowrite", rd, 32'h80223344);
        chk("oor_st_nowrite_err", {31'd0, er}, 32'd0);

        // 5: backpressure on the response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h20;
        req_type   = 3'b010;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h10;
        lat = 0;
        while (!resp_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 1 + WAIT);
        hold_rd = resp_rdata;
        hold_er = resp_err;
        chk("bp_rdata0", hold_rd, 32'hA5A50000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'hA5A50000);
            chk("bp_err", {31'd0, resp_err}, {31'd0, hold_er});
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

        // 6: reset during ACCESS of a store drops it
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_type  = 3'b010;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("acc_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_rdata",      resp_rdata,          32'd0);
        chk("mid_rst_err",        {31'd0, resp_err},   32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("after_rst_old_data", rd, 32'h80223344);

        // Misaligned word store
        xact(1'b1, 32'h11, 3'b010, 32'h55667788, rd, er, lat);
`ifdef DMEM_MISALIGN_CHK_EN
        chk("mis_sw_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("mis_sw_nowrite", rd, 32'h80223344);
`else
        chk("mis_sw_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        chk("mis_sw_aligned", rd, 32'h55667788);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
